// File: rtl/cordic_gain_normalizer.sv
// rtl/cordic_gain_normalizer.sv - removes CORDIC gain, flags poor convergence, buffers results
// Two register stages feed a show-ahead FIFO with a valid/ready output handshake.
module cordic_gain_normalizer #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 12,
  parameter int CODE_WIDTH = 8,
  parameter int INV_GAIN   = 2487,
  parameter int RESID_TOL  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  mag_in,
  input  logic [WIDTH-1:0]                  resid_in,
  input  logic [WIDTH-1:0]                  angle_in,
  input  logic [CODE_WIDTH-1:0]             code_in,
  input  logic                              valid_in,
  output logic [WIDTH-1:0]                  mag_out,
  output logic [WIDTH-1:0]                  angle_out,
  output logic [CODE_WIDTH-1:0]             code_out,
  output logic                              conv_err_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              overflow,
  output logic [7:0]                        drop_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int EW = 2*WIDTH + CODE_WIDTH + 1;
  localparam logic [2*WIDTH-1:0] INV_GAIN_W = (2*WIDTH)'(INV_GAIN);
  localparam logic [2*WIDTH-1:0] ROUND_W    = (2*WIDTH)'(1) << (FRAC_BITS-1);
  localparam logic [WIDTH:0]     TOL_W      = (WIDTH+1)'(RESID_TOL);

  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic                  err_a_q, err_a_d;
  logic [WIDTH-1:0]      angle_a_q, angle_a_d;
  logic [CODE_WIDTH-1:0] code_a_q, code_a_d;
  logic                  valid_a_q, valid_a_d;

  logic [WIDTH-1:0]      mag_b_q, mag_b_d;
  logic                  err_b_q, err_b_d;
  logic [WIDTH-1:0]      angle_b_q, angle_b_d;
  logic [CODE_WIDTH-1:0] code_b_q, code_b_d;
  logic                  valid_b_q, valid_b_d;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_q, drop_d;

  logic [WIDTH-1:0]      mag_pos;
  logic [WIDTH:0]        resid_ext, resid_abs;
  logic [2*WIDTH-1:0]    rounded;
  logic                  push, pop, full, accept, drop;

  // Stage A: clamp negative magnitudes, multiply by 1/K, test residual in WIDTH+1 bits
  always_comb begin
    mag_pos   = mag_in[WIDTH-1] ? '0 : mag_in;
    resid_ext = {resid_in[WIDTH-1], resid_in};
    resid_abs = resid_ext[WIDTH] ? (~resid_ext + 1'b1) : resid_ext;
    prod_d    = {{WIDTH{1'b0}}, mag_pos} * INV_GAIN_W;
    err_a_d   = resid_abs > TOL_W;
    angle_a_d = angle_in;
    code_a_d  = code_in;
    valid_a_d = valid_in;
  end

  // Stage B: INV_GAIN < 2^FRAC_BITS keeps the rounded result within WIDTH-1 magnitude bits
  always_comb begin
    rounded   = prod_q + ROUND_W;
    mag_b_d   = WIDTH'(rounded >> FRAC_BITS);
    err_b_d   = err_a_q;
    angle_b_d = angle_a_q;
    code_b_d  = code_a_q;
    valid_b_d = valid_a_q;
  end

  always_comb begin
    push     = valid_b_q;
    full     = count_q == LW'(FIFO_DEPTH);
    pop      = (count_q != '0) && ready_in;
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = {mag_b_q, angle_b_q, code_b_q, err_b_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q || drop;
    drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_q     <= '0;
      err_a_q    <= 1'b0;
      angle_a_q  <= '0;
      code_a_q   <= '0;
      valid_a_q  <= 1'b0;
      mag_b_q    <= '0;
      err_b_q    <= 1'b0;
      angle_b_q  <= '0;
      code_b_q   <= '0;
      valid_b_q  <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      prod_q     <= prod_d;
      err_a_q    <= err_a_d;
      angle_a_q  <= angle_a_d;
      code_a_q   <= code_a_d;
      valid_a_q  <= valid_a_d;
      mag_b_q    <= mag_b_d;
      err_b_q    <= err_b_d;
      angle_b_q  <= angle_b_d;
      code_b_q   <= code_b_d;
      valid_b_q  <= valid_b_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign {mag_out, angle_out, code_out, conv_err_out} = mem_q[rd_ptr_q];
  assign valid_out  = count_q != '0;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_cordic_gain_normalizer.sv
// tb/tb_cordic_gain_normalizer.sv - directed vector bench for cordic_gain_normalizer
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cordic_gain_normalizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mag_in = '0, resid_in = '0, angle_in = '0;
  logic [7:0]  code_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [15:0] mag_out, angle_out;
  logic [7:0]  code_out;
  logic        conv_err_out, valid_out, overflow;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  cordic_gain_normalizer dut (
    .clock(clock), .reset(reset),
    .mag_in(mag_in), .resid_in(resid_in), .angle_in(angle_in),
    .code_in(code_in), .valid_in(valid_in),
    .mag_out(mag_out), .angle_out(angle_out), .code_out(code_out),
    .conv_err_out(conv_err_out), .valid_out(valid_out), .ready_in(ready_in),
    .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] mag;
    logic [15:0] resid;
    logic [15:0] angle;
    logic [7:0]  code;
    logic [15:0] exp_mag;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] m, input logic [15:0] r, input logic [15:0] a, input logic [7:0] c);
    mag_in = m; resid_in = r; angle_in = a; code_in = c; valid_in = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid_out"}, 32'(valid_out), 0);
    check({tag, ".mag_out"}, 32'(mag_out), 0);
    check({tag, ".angle_out"}, 32'(angle_out), 0);
    check({tag, ".code_out"}, 32'(code_out), 0);
    check({tag, ".conv_err"}, 32'(conv_err_out), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
    check({tag, ".drop_count"}, 32'(drop_count), 0);
    check({tag, ".fifo_level"}, 32'(fifo_level), 0);
  endtask

  initial begin
    vecs[0] = '{16'd6745,  16'd3,     16'd3217,  8'h5A, 16'd4095,  1'b0};
    vecs[1] = '{16'd32767, 16'd0,     16'd100,   8'h01, 16'd19895, 1'b0};
    vecs[2] = '{16'd0,     16'd0,     16'hF000,  8'h02, 16'd0,     1'b0};
    vecs[3] = '{16'hFFFB,  16'd0,     16'd7,     8'h03, 16'd0,     1'b0};
    vecs[4] = '{16'd1000,  16'd17,    16'd0,     8'h04, 16'd607,   1'b1};
    vecs[5] = '{16'd1000,  16'hFFF0,  16'd0,     8'h05, 16'd607,   1'b0};
    vecs[6] = '{16'd1000,  16'h8000,  16'd0,     8'h06, 16'd607,   1'b1};
    vecs[7] = '{16'd4096,  16'd16,    16'h8000,  8'hFF, 16'd2487,  1'b0};
    vecs[8] = '{16'd1,     16'hFFEF,  16'd1,     8'h08, 16'd1,     1'b1};
    vecs[9] = '{16'h8000,  16'h7FFF,  16'd2,     8'h09, 16'd0,     1'b1};

    #2;
    check_zero_outputs("reset");
    step();
    reset = 1'b0;
    ready_in = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].mag, vecs[i].resid, vecs[i].angle, vecs[i].code);
      step();
      valid_in = 1'b0;
      step();
      check($sformatf("v%0d.early_valid", i), 32'(valid_out), 0);
      step();
      check($sformatf("v%0d.valid", i), 32'(valid_out), 1);
      check($sformatf("v%0d.mag", i), 32'(mag_out), 32'(vecs[i].exp_mag));
      check($sformatf("v%0d.angle", i), 32'(angle_out), 32'(vecs[i].angle));
      check($sformatf("v%0d.code", i), 32'(code_out), 32'(vecs[i].code));
      check($sformatf("v%0d.err", i), 32'(conv_err_out), 32'(vecs[i].exp_err));
      step();
      check($sformatf("v%0d.valid_drop", i), 32'(valid_out), 0);
    end

    // back-to-back samples emerge on consecutive cycles
    drive(16'd6745, 16'd0, 16'd11, 8'd10); step();
    drive(16'd4096, 16'd0, 16'd12, 8'd11); step();
    drive(16'd1,    16'd0, 16'd13, 8'd12); step();
    valid_in = 1'b0;
    check("b2b.code0", 32'(code_out), 10);
    check("b2b.mag0", 32'(mag_out), 4095);
    step();
    check("b2b.code1", 32'(code_out), 11);
    check("b2b.mag1", 32'(mag_out), 2487);
    step();
    check("b2b.code2", 32'(code_out), 12);
    check("b2b.mag2", 32'(mag_out), 1);
    check("b2b.level", 32'(fifo_level), 1);
    step();
    check("b2b.empty", 32'(valid_out), 0);

    // overflow: six samples into a stalled 4-deep FIFO
    ready_in = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      drive(16'd100, 16'd0, 16'd0, 8'(c));
      step();
    end
    valid_in = 1'b0;
    step();
    step();
    check("ovf.level", 32'(fifo_level), 4);
    check("ovf.drop_count", 32'(drop_count), 2);
    check("ovf.overflow", 32'(overflow), 1);
    ready_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("ovf.pop_valid%0d", c), 32'(valid_out), 1);
      check($sformatf("ovf.pop_code%0d", c), 32'(code_out), 32'(c));
      step();
    end
    check("ovf.drained", 32'(valid_out), 0);
    check("ovf.sticky", 32'(overflow), 1);

    // full FIFO with a push and pop on the same edge
    ready_in = 1'b0;
    for (int c = 21; c <= 24; c++) begin
      drive(16'd100, 16'd0, 16'd0, 8'(c));
      step();
    end
    valid_in = 1'b0;
    step();
    step();
    check("fp.level_full", 32'(fifo_level), 4);
    drive(16'd100, 16'd0, 16'd0, 8'd25);
    step();
    valid_in = 1'b0;
    step();
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check("fp.level", 32'(fifo_level), 4);
    check("fp.drop_count", 32'(drop_count), 2);
    check("fp.head", 32'(code_out), 22);
    ready_in = 1'b1;
    for (int c = 22; c <= 25; c++) begin
      check($sformatf("fp.order%0d", c), 32'(code_out), 32'(c));
      step();
    end
    check("fp.drained", 32'(valid_out), 0);

    // reset with three entries held and two in flight
    ready_in = 1'b0;
    for (int c = 31; c <= 33; c++) begin
      drive(16'd100, 16'd0, 16'd0, 8'(c));
      step();
    end
    valid_in = 1'b0;
    step();
    step();
    check("rst.held", 32'(fifo_level), 3);
    drive(16'd100, 16'd0, 16'd0, 8'd34); step();
    drive(16'd100, 16'd0, 16'd0, 8'd35); step();
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("rst");
    step();
    reset = 1'b0;
    ready_in = 1'b1;
    drive(16'd6745, 16'd20, 16'd55, 8'h77);
    step();
    valid_in = 1'b0;
    check("rst.no_ghost1", 32'(valid_out), 0);
    step();
    check("rst.no_ghost2", 32'(valid_out), 0);
    step();
    check("rst.new_valid", 32'(valid_out), 1);
    check("rst.new_code", 32'(code_out), 32'h77);
    check("rst.new_mag", 32'(mag_out), 4095);
    check("rst.new_err", 32'(conv_err_out), 1);
    check("rst.drop_count", 32'(drop_count), 0);
    check("rst.overflow", 32'(overflow), 0);
    step();
    check("rst.empty", 32'(valid_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
